// File: rtl/pcie_egress_tlp_sender_if.sv
// Signal bundle between the egress TLP sender, its control/ppfifo requester and the PCIe TX stream.
// The master modport is the sender side; the slave modport is the environment around it.
interface pcie_egress_tlp_sender_if;
  logic        i_enable;
  logic        o_finished;
  logic [7:0]  i_tlp_command;
  logic [13:0] i_tlp_flags;
  logic [31:0] i_tlp_address;
  logic [15:0] i_tlp_requester_id;
  logic [7:0]  i_tlp_tag;
  logic        i_pcie_fc_ready;
  logic        i_fifo_rdy;
  logic        o_fifo_act;
  logic [23:0] i_fifo_size;
  logic        o_fifo_stb;
  logic [31:0] i_fifo_data;
  logic [31:0] o_axi_tdata;
  logic [3:0]  o_axi_tkeep;
  logic        o_axi_tvalid;
  logic        i_axi_tready;
  logic        o_axi_tlast;
  logic        o_overflow;
  logic        o_busy;

  modport master (
    input  i_enable, i_tlp_command, i_tlp_flags, i_tlp_address, i_tlp_requester_id,
           i_tlp_tag, i_pcie_fc_ready, i_fifo_rdy, i_fifo_size, i_fifo_data, i_axi_tready,
    output o_finished, o_fifo_act, o_fifo_stb, o_axi_tdata, o_axi_tkeep, o_axi_tvalid,
           o_axi_tlast, o_overflow, o_busy
  );

  modport slave (
    output i_enable, i_tlp_command, i_tlp_flags, i_tlp_address, i_tlp_requester_id,
           i_tlp_tag, i_pcie_fc_ready, i_fifo_rdy, i_fifo_size, i_fifo_data, i_axi_tready,
    input  o_finished, o_fifo_act, o_fifo_stb, o_axi_tdata, o_axi_tkeep, o_axi_tvalid,
           o_axi_tlast, o_overflow, o_busy
  );
endinterface

// File: rtl/pcie_egress_tlp_sender.sv
// Egress TLP sender: claims a ppfifo read buffer, emits a 3DW header and the payload on AXI-stream.
// Optional macro PCIE_EGRESS_BYTE_SWAP_EN byte-swaps payload beats (header DWs untouched).
module pcie_egress_tlp_sender #(
  parameter int MAX_PAYLOAD_DW = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  pcie_egress_tlp_sender_if.master bus
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FC,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        cmd_q;
  logic [13:0]       flags_q;
  logic [31:0]       addr_q;
  logic [15:0]       req_id_q;
  logic [7:0]        tag_q;
  logic [9:0]        len_q;
  logic [23:0]       size_q;
  logic [9:0]        cnt_q;
  logic [23:0]       drain_q;
  logic              finished_q;
  logic              overflow_q;

  logic              tvalid;
  logic              tlast;
  logic              stb;
  logic [DATA_W-1:0] tdata;
  logic              start;
  logic              beat_last;
  logic [DATA_W-1:0] dw0, dw1, dw2;

  function automatic logic [9:0] clamp_len(input logic [23:0] sz);
    if (sz > 24'(MAX_PAYLOAD_DW)) return 10'(MAX_PAYLOAD_DW);
    return sz[9:0];
  endfunction

  function automatic logic [DATA_W-1:0] payload_fmt(input logic [DATA_W-1:0] d);
`ifdef PCIE_EGRESS_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  assign start     = bus.i_enable && bus.i_fifo_rdy;
  assign beat_last = (cnt_q == (len_q - 10'd1));

  assign dw0 = {cmd_q, flags_q, len_q};
  assign dw1 = {req_id_q, tag_q, (len_q == 10'd1) ? 4'h0 : 4'hF, 4'hF};
  assign dw2 = addr_q & 32'hFFFF_FFFC;

  // Request fields are captured once, on leaving IDLE, and held for the whole TLP
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cmd_q    <= bus.i_tlp_command;
      flags_q  <= bus.i_tlp_flags;
      addr_q   <= bus.i_tlp_address;
      req_id_q <= bus.i_tlp_requester_id;
      tag_q    <= bus.i_tlp_tag;
      size_q   <= bus.i_fifo_size;
      len_q    <= clamp_len(bus.i_fifo_size);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      drain_q    <= '0;
    end else begin
      state      <= state_nxt;
      finished_q <= (state_nxt == S_DONE) && (state != S_DONE);
      overflow_q <= (state == S_IDLE) && (state_nxt == S_WAIT_FC) &&
                    (bus.i_fifo_size > 24'(MAX_PAYLOAD_DW));
      if (state == S_IDLE)
        cnt_q <= '0;
      else if (state == S_DATA && bus.i_axi_tready)
        cnt_q <= cnt_q + 10'd1;
      // Words beyond the truncated length still have to be popped to free the buffer
      if (state == S_DATA && bus.i_axi_tready && beat_last)
        drain_q <= size_q - {14'd0, len_q};
      else if (state == S_DRAIN && drain_q != '0)
        drain_q <= drain_q - 24'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    stb       = 1'b0;
    tdata     = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT_FC;
      end
      S_WAIT_FC: begin
        if (size_q == '0)             state_nxt = S_DONE;
        else if (bus.i_pcie_fc_ready) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        tvalid = 1'b1;
        tdata  = dw0;
        if (bus.i_axi_tready) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        tvalid = 1'b1;
        tdata  = dw1;
        if (bus.i_axi_tready) state_nxt = S_HDR2;
      end
      S_HDR2: begin
        tvalid = 1'b1;
        tdata  = dw2;
        if (bus.i_axi_tready) state_nxt = S_DATA;
      end
      S_DATA: begin
        tvalid = 1'b1;
        tdata  = payload_fmt(bus.i_fifo_data);
        tlast  = beat_last;
        stb    = bus.i_axi_tready;
        if (bus.i_axi_tready && beat_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == '0) state_nxt = S_DONE;
        else               stb = 1'b1;
      end
      S_DONE: begin
        if (!bus.i_enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_axi_tdata  = tdata;
  assign bus.o_axi_tvalid = tvalid;
  assign bus.o_axi_tlast  = tlast;
  assign bus.o_axi_tkeep  = 4'hF;
  assign bus.o_fifo_stb   = stb;
  assign bus.o_fifo_act   = (state != S_IDLE) && (state != S_DONE);
  assign bus.o_busy       = (state != S_IDLE);
  assign bus.o_finished   = finished_q;
  assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_pcie_egress_tlp_sender.sv
// Directed bench for pcie_egress_tlp_sender: a default instance plus a MAX_PAYLOAD_DW=4 instance
// driven with the same requests; each has its own ppfifo model and beat monitor.
module tb_pcie_egress_tlp_sender;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        enable, fc, fifo_rdy, tready, tog;
  logic [7:0]  cmd, tag;
  logic [13:0] flags;
  logic [31:0] addr;
  logic [15:0] req;
  logic [23:0] size;
  int unsigned idx_a = 0, idx_b = 0, start_a = 0, start_b = 0;

  pcie_egress_tlp_sender_if ifa ();
  pcie_egress_tlp_sender_if ifb ();

  assign ifa.i_enable = enable;           assign ifb.i_enable = enable;
  assign ifa.i_tlp_command = cmd;         assign ifb.i_tlp_command = cmd;
  assign ifa.i_tlp_flags = flags;         assign ifb.i_tlp_flags = flags;
  assign ifa.i_tlp_address = addr;        assign ifb.i_tlp_address = addr;
  assign ifa.i_tlp_requester_id = req;    assign ifb.i_tlp_requester_id = req;
  assign ifa.i_tlp_tag = tag;             assign ifb.i_tlp_tag = tag;
  assign ifa.i_pcie_fc_ready = fc;        assign ifb.i_pcie_fc_ready = fc;
  assign ifa.i_fifo_rdy = fifo_rdy;       assign ifb.i_fifo_rdy = fifo_rdy;
  assign ifa.i_fifo_size = size;          assign ifb.i_fifo_size = size;
  assign ifa.i_axi_tready = tready;       assign ifb.i_axi_tready = tready;
  assign ifa.i_fifo_data = 32'hA500_0000 + idx_a;
  assign ifb.i_fifo_data = 32'hB600_0000 + idx_b;

  pcie_egress_tlp_sender dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  pcie_egress_tlp_sender #(.MAX_PAYLOAD_DW(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  int checks = 0, errors = 0;

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d);
`ifdef PCIE_EGRESS_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // ppfifo models: first-word-fall-through, advance on each pop
  always @(posedge clk) begin
    if (!rst && ifa.o_fifo_stb) idx_a <= idx_a + 1;
    if (!rst && ifb.o_fifo_stb) idx_b <= idx_b + 1;
  end

  logic [31:0] beats_a[$], beats_b[$];
  logic        lasts_a[$], lasts_b[$];
  int stb_a, stb_b, fin_a, fin_b, ovf_a, ovf_b, bad_a, hold_err, stalls;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.o_axi_tvalid && tready) begin
        beats_a.push_back(ifa.o_axi_tdata);
        lasts_a.push_back(ifa.o_axi_tlast);
      end
      if (ifb.o_axi_tvalid && tready) begin
        beats_b.push_back(ifb.o_axi_tdata);
        lasts_b.push_back(ifb.o_axi_tlast);
      end
      if (ifa.o_fifo_stb) stb_a++;
      if (ifb.o_fifo_stb) stb_b++;
      if (ifa.o_finished) fin_a++;
      if (ifb.o_finished) fin_b++;
      if (ifa.o_overflow) ovf_a++;
      if (ifb.o_overflow) ovf_b++;
      if (ifa.o_axi_tlast && !ifa.o_axi_tvalid) bad_a++;
      if (prev_stall && (!ifa.o_axi_tvalid || ifa.o_axi_tdata !== prev_data)) hold_err++;
      if (ifa.o_axi_tvalid && !tready) stalls++;
      prev_stall = ifa.o_axi_tvalid && !tready;
      prev_data  = ifa.o_axi_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (tog) begin
      #1;
      tready = ~tready;
    end
  end

  task automatic kick();
    beats_a.delete(); lasts_a.delete(); beats_b.delete(); lasts_b.delete();
    stb_a = 0; stb_b = 0; fin_a = 0; fin_b = 0; ovf_a = 0; ovf_b = 0;
    bad_a = 0; hold_err = 0; stalls = 0;
    start_a = idx_a; start_b = idx_b;
    enable = 1'b1;
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (!(fin_a > 0 && fin_b > 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({t, "_done"}, (fin_a > 0 && fin_b > 0), 1'b1);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({t, "_busy_after"}, ifa.o_busy, 1'b0);
    check({t, "_act_after"}, ifa.o_fifo_act, 1'b0);
  endtask

  task automatic check_tlp(input string t, input bit sel_b, input int n,
                           input logic [31:0] dw0, input logic [31:0] dw1,
                           input logic [31:0] dw2, input logic [31:0] base);
    int sz, nl, lp;
    logic [31:0] e, got;
    logic l;
    sz = sel_b ? beats_b.size() : beats_a.size();
    check({t, "_nbeats"}, sz, n + 3);
    nl = 0; lp = -1;
    for (int i = 0; i < sz; i++) begin
      got = sel_b ? beats_b[i] : beats_a[i];
      l   = sel_b ? lasts_b[i] : lasts_a[i];
      if (l) begin nl++; lp = i; end
      if (i < n + 3) begin
        e = (i == 0) ? dw0 : (i == 1) ? dw1 : (i == 2) ? dw2 : fmt(base + 32'(i - 3));
        check($sformatf("%s_beat%0d", t, i), got, e);
      end
    end
    check({t, "_nlast"}, nl, 1);
    check({t, "_lastpos"}, lp, n + 2);
    check({t, "_last_wo_valid"}, bad_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt, n;
    rst = 1'b1; enable = 1'b0; fc = 1'b1; fifo_rdy = 1'b1; tready = 1'b1; tog = 1'b0;
    cmd = '0; flags = '0; addr = '0; req = '0; tag = '0; size = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", ifa.o_axi_tvalid, 1'b0);
    check("rst_tlast", ifa.o_axi_tlast, 1'b0);
    check("rst_tdata", ifa.o_axi_tdata, 32'h0);
    check("rst_tkeep", ifa.o_axi_tkeep, 4'hF);
    check("rst_act", ifa.o_fifo_act, 1'b0);
    check("rst_stb", ifa.o_fifo_stb, 1'b0);
    check("rst_busy", ifa.o_busy, 1'b0);
    check("rst_fin", ifa.o_finished, 1'b0);
    check("rst_ovf", ifa.o_overflow, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // size 8 basic TLP with start latency
    cmd = 8'h40; flags = 14'h0; addr = 32'h1000_0040; req = 16'h0100; tag = 8'h05; size = 24'd8;
    kick();
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (ifa.o_axi_tvalid) break;
    end
    check("s8_latency", lat, 2);
    wait_done("s8");
    check_tlp("s8", 1'b0, 8, 32'h4000_0008, 32'h0100_05FF, 32'h1000_0040, 32'hA500_0000 + start_a);
    check("s8_stb", stb_a, 8);
    check("s8_fin", fin_a, 1);
    check("s8_ovf", ovf_a, 0);

    // single-DW TLP, last_be cleared, address low bits masked
    cmd = 8'h60; flags = 14'h0001; addr = 32'h2000_0007; req = 16'hABCD; tag = 8'h12; size = 24'd1;
    kick();
    wait_done("s1");
    check_tlp("s1", 1'b0, 1, 32'h6000_0401, 32'hABCD_120F, 32'h2000_0004, 32'hA500_0000 + start_a);
    check("s1_stb", stb_a, 1);

    // backpressure every other cycle; fields changed after capture must be ignored
    cmd = 8'h40; flags = 14'h3FFF; addr = 32'hFFFF_FFF0; req = 16'h1234; tag = 8'hFE; size = 24'd4;
    tog = 1'b1;
    kick();
    @(posedge clk); #1;
    cmd = 8'hEE; addr = 32'h0; size = 24'd9; tag = 8'h00;
    wait_done("tog");
    tog = 1'b0;
    #1 tready = 1'b1;
    @(posedge clk); #1;
    check_tlp("tog", 1'b0, 4, 32'h40FF_FC04, 32'h1234_FEFF, 32'hFFFF_FFF0, 32'hA500_0000 + start_a);
    check("tog_stb", stb_a, 4);
    check("tog_hold", hold_err, 0);
    check("tog_stalls_seen", stalls > 0, 1'b1);
    check("tog_b_no_ovf", ovf_b, 0);

    // flow-control credit withheld
    cmd = 8'h40; flags = 14'h0; addr = 32'h0000_0080; req = 16'h0001; tag = 8'h01; size = 24'd2;
    fc = 1'b0;
    kick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ifa.o_axi_tvalid) cnt++;
    end
    check("fc_no_tvalid", cnt, 0);
    check("fc_act_held", ifa.o_fifo_act, 1'b1);
    fc = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (ifa.o_axi_tvalid) break;
    end
    check("fc_latency", lat, 1);
    wait_done("fc");
    check_tlp("fc", 1'b0, 2, 32'h4000_0002, 32'h0001_01FF, 32'h0000_0080, 32'hA500_0000 + start_a);

    // oversize buffer on the MAX_PAYLOAD_DW=4 instance
    cmd = 8'h40; flags = 14'h0; addr = 32'h0000_0100; req = 16'h0000; tag = 8'h00; size = 24'd6;
    kick();
    wait_done("ovf");
    check_tlp("ovf", 1'b1, 4, 32'h4000_0004, 32'h0000_00FF, 32'h0000_0100, 32'hB600_0000 + start_b);
    check("ovf_pulse", ovf_b, 1);
    check("ovf_stb", stb_b, 6);
    check("ovf_fin", fin_b, 1);
    check("ovf_act_b", ifb.o_fifo_act, 1'b0);
    check("ovf_a_none", ovf_a, 0);
    check("ovf_a_stb", stb_a, 6);

    // empty buffer: finish without a TLP
    size = 24'd0;
    kick();
    wait_done("empty");
    check("empty_beats", beats_a.size(), 0);
    check("empty_stb", stb_a, 0);
    check("empty_fin", fin_a, 1);

    // reset during the second payload beat, then a clean restart with enable held
    cmd = 8'h40; flags = 14'h0; addr = 32'h3000_0000; req = 16'h0002; tag = 8'h07; size = 24'd4;
    kick();
    n = 0;
    while (beats_a.size() < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_reached", beats_a.size(), 4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_tvalid", ifa.o_axi_tvalid, 1'b0);
    check("rstmid_act", ifa.o_fifo_act, 1'b0);
    check("rstmid_busy", ifa.o_busy, 1'b0);
    check("rstmid_fin", fin_a, 0);
    rst = 1'b0;
    kick();
    wait_done("rstmid");
    check_tlp("rstmid", 1'b0, 4, 32'h4000_0004, 32'h0002_07FF, 32'h3000_0000, 32'hA500_0000 + start_a);
    check("rstmid_stb", stb_a, 4);
    check("rstmid_fin1", fin_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
